window_fifo: RTL and testbench
==============================

# window_fifo

Parametrised first-word-fall-through sample buffer for the time-series predictor datapath, successor to the basic push/pop FIFO. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags, and a registered random-access peek port. The peek port lets the predictor read any of the last N buffered samples (the history window) without popping them.

## Interface
- DEPTH_BITS, 3, log2 of entry count; DEPTH = 2**DEPTH_BITS entries
- DATA_WIDTH, 8, width of each sample
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents, count and error flags
- push  in  1  write val_in this cycle
- val_in  in  DATA_WIDTH  sample to write
- pop  in  1  consume head entry this cycle
- val_out  out  DATA_WIDTH  head entry (FWFT, combinational from storage); 0 when empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  DEPTH_BITS+1  current occupancy, 0..DEPTH
- peek_idx  in  DEPTH_BITS  offset from head (0 = oldest entry)
- peek_out  out  DATA_WIDTH  registered entry at head+peek_idx
- peek_valid  out  1  registered; 1 when peek_idx < count at sampling edge
- overflow  out  1  sticky: push rejected because full without pop
- underflow  out  1  sticky: pop while empty

## Operation
- Storage: DEPTH x DATA_WIDTH array; wr_ptr and rd_ptr are DEPTH_BITS wide and wrap modulo DEPTH. count is tracked explicitly, not derived from pointers.
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, peek_out=0, peek_valid=0. Outputs: empty=1, full=0, val_out=0, almost_empty=1, almost_full=(AF_LEVEL==0). Array contents are not reset.
- Priority on each edge: flush, then push/pop.
- flush=1: pointers, count, overflow and underflow go to 0; push and pop that cycle are ignored; peek_valid=0 next cycle.
- Push accepted when count < DEPTH, or when full with an accepted pop the same cycle. On accept: mem[wr_ptr] <= val_in, wr_ptr++.
- Pop accepted when count > 0. On accept: rd_ptr++. Pop while empty is ignored and sets underflow.
- Push while full without pop is dropped and sets overflow. Contents are unchanged.
- Simultaneous push and pop, 0 < count < DEPTH: both are accepted and count is unchanged.
- Simultaneous push and pop when empty: push accepted, pop ignored, underflow set, count becomes 1.
- Simultaneous push and pop when full: both accepted, count stays DEPTH, and the new word lands in the freed slot.
- count: +1 on push-only accept, -1 on pop-only accept, else held.
- Peek: each edge, peek_out <= mem[(rd_ptr + peek_idx) mod DEPTH] and peek_valid <= (peek_idx < count), both using pre-edge pointer and count values. peek_out is don't-care when peek_valid=0 (implementation drives last read value).
- Sticky flags clear only on reset or flush.

## Timing
- Write-to-read latency: a word pushed at edge N is visible on val_out after edge N when it becomes head (FWFT, 0 extra cycles). empty deasserts after the same edge.
- Pop at edge N: val_out shows the next entry after edge N.
- Flags full/empty/almost_*: combinational from registered count, valid after the edge that updates count.
- Peek latency: 1 cycle. The result at edge N+1 reflects state and peek_idx before edge N+1, excluding that edge's push/pop.
- overflow/underflow assert after the offending edge.

## Test plan
- Reset then push 8 samples 1..8 (DEPTH_BITS=3) -> count 8, full=1, almost_full=1 from count 7, val_out=1; a 9th push of 9 -> overflow=1, contents unchanged, popping yields 1..8 then empty=1.
- Pop on empty after reset -> underflow=1, count 0; simultaneous push 5 and pop on empty -> count 1, val_out=5.
- Full buffer plus simultaneous push 9 and pop -> val_out advances 1→2, count stays 8; drain yields 2..9, exercising pointer wrap.
- Push 10,20,30, then peek_idx=2 -> peek_out=30, peek_valid=1 next cycle; peek_idx=3 -> peek_valid=0; after one pop, peek_idx=0 -> 20.
- Half-full buffer with overflow set, then flush with push asserted -> count 0, empty=1, overflow=0, pushed word not stored.
- Assert rst low asynchronously mid-burst (between edges) -> count=0, empty=1, flags 0 immediately; release and push 7 -> val_out=7.

Source files
------------

// File: rtl/window_fifo.sv
// First-word-fall-through sample buffer with occupancy count, thresholds, flush,
// sticky error flags and a registered random-access peek into the history window.
module window_fifo #(
  parameter int DEPTH_BITS = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = (1 << DEPTH_BITS) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] val_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] val_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_BITS:0]   count,
  input  logic [DEPTH_BITS-1:0] peek_idx,
  output logic [DATA_WIDTH-1:0] peek_out,
  output logic                  peek_valid,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_CNT   = (DEPTH_BITS + 1)'(AF_LEVEL);
  localparam logic [DEPTH_BITS:0] AE_CNT   = (DEPTH_BITS + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] peek_addr;
  logic                  pop_ok;
  logic                  push_ok;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign val_out      = empty ? '0 : mem[rd_ptr];

  // A pop frees a slot in the same edge, so a full buffer still accepts a push alongside it.
  assign pop_ok    = pop && !empty && !flush;
  assign push_ok   = push && (!full || pop_ok) && !flush;
  assign peek_addr = rd_ptr + peek_idx;

  // NOTE: storage has no reset; only pointers and count define which words are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= val_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end

  // Peek samples pre-edge pointer and count, so this edge's push/pop is not reflected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peek_out   <= '0;
      peek_valid <= 1'b0;
    end else begin
      peek_out   <= mem[peek_addr];
      peek_valid <= !flush && ({1'b0, peek_idx} < count);
    end
  end

endmodule

// File: tb/tb_window_fifo.sv
// Self-checking bench for window_fifo: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_window_fifo;

  localparam int DB    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << DB;
  localparam int AF    = DEPTH - 1;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] val_in = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] val_out;
  logic          full, empty, almost_full, almost_empty;
  logic [DB:0]   count;
  logic [DB-1:0] peek_idx = '0;
  logic [DW-1:0] peek_out;
  logic          peek_valid, overflow, underflow;

  window_fifo #(.DEPTH_BITS(DB), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .val_in(val_in), .pop(pop),
    .val_out(val_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .peek_idx(peek_idx), .peek_out(peek_out),
    .peek_valid(peek_valid), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a plain queue holding live samples, oldest first.
  int m_q[$];
  bit m_ovf, m_udf, m_pv;
  int m_po;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_udf = 0; m_pv = 0; m_po = 0;
  endtask

  // One clock: drive inputs, advance the model from its pre-edge state, sample after the edge.
  task automatic step(input bit p, input int v, input bit o, input bit f, input int pi);
    bit take_pop;
    push = p; val_in = DW'(v); pop = o; flush = f; peek_idx = DB'(pi);
    m_pv = (pi < m_q.size()) && !f;
    if (pi < m_q.size()) m_po = m_q[pi];
    if (f) begin
      m_q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      take_pop = o && (m_q.size() > 0);
      if (p && m_q.size() == DEPTH && !o) m_ovf = 1;
      if (o && m_q.size() == 0) m_udf = 1;
      if (take_pop) void'(m_q.pop_front());
      if (p && (m_q.size() < DEPTH)) m_q.push_back(v & ((1 << DW) - 1));
    end
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = m_q.size();
    check({tag, ".count"},        32'(count),        32'(sz));
    check({tag, ".empty"},        32'(empty),        32'(sz == 0));
    check({tag, ".full"},         32'(full),         32'(sz == DEPTH));
    check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
    check({tag, ".val_out"},      32'(val_out),      32'(sz > 0 ? m_q[0] : 0));
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_udf));
    check({tag, ".peek_valid"},   32'(peek_valid),   32'(m_pv));
    if (m_pv) check({tag, ".peek_out"}, 32'(peek_out), 32'(m_po));
  endtask

  typedef struct {
    bit p; int v; bit o; bit f;
    int e_count; int e_val; bit e_ovf; bit e_udf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Directed table: expectations written out by hand from the buffer's rules.
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 1});   // pop on empty
    vecs.push_back('{1, 5, 1, 0, 1, 5, 0, 1});   // push+pop on empty
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0});   // flush clears underflow
    for (int k = 1; k <= 8; k++) vecs.push_back('{1, k, 0, 0, k, 1, 0, 0});
    vecs.push_back('{1, 9, 0, 0, 8, 1, 1, 0});   // overflow, contents kept
    vecs.push_back('{1, 9, 1, 0, 8, 2, 1, 0});   // full push+pop
    vecs.push_back('{1, 3, 0, 1, 0, 0, 0, 0});   // flush beats push

    model_reset();
    #12;
    check("reset.count",        32'(count),        0);
    check("reset.empty",        32'(empty),        1);
    check("reset.full",         32'(full),         0);
    check("reset.val_out",      32'(val_out),      0);
    check("reset.almost_empty", 32'(almost_empty), 1);
    check("reset.almost_full",  32'(almost_full),  0);
    check("reset.peek_out",     32'(peek_out),     0);
    check("reset.peek_valid",   32'(peek_valid),   0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].p, vecs[i].v, vecs[i].o, vecs[i].f, 0);
      check($sformatf("vec%0d.count", i),     32'(count),     32'(vecs[i].e_count));
      check($sformatf("vec%0d.val_out", i),   32'(val_out),   32'(vecs[i].e_val));
      check($sformatf("vec%0d.overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].e_udf));
      check($sformatf("vec%0d.full", i),      32'(full),      32'(vecs[i].e_count == DEPTH));
      check($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].e_count >= AF));
    end

    // Wrap: fill, full push+pop, then drain 2..9.
    for (int k = 1; k <= 8; k++) step(1, k, 0, 0, 0);
    step(1, 9, 1, 0, 0);
    check("wrap.count", 32'(count), 8);
    check("wrap.head",  32'(val_out), 2);
    for (int k = 2; k <= 9; k++) begin
      check("drain.head", 32'(val_out), 32'(k));
      step(0, 0, 1, 0, 0);
    end
    check("drain.empty", 32'(empty), 1);
    check_model("drain");

    // Peek window.
    step(1, 10, 0, 0, 0);
    step(1, 20, 0, 0, 0);
    step(1, 30, 0, 0, 0);
    step(0, 0, 0, 0, 2);
    check("peek2.out",   32'(peek_out),   30);
    check("peek2.valid", 32'(peek_valid), 1);
    step(0, 0, 0, 0, 3);
    check("peek3.valid", 32'(peek_valid), 0);
    step(0, 0, 1, 0, 0);
    check("peek_pre_pop.out", 32'(peek_out), 10);
    step(0, 0, 0, 0, 0);
    check("peek_post_pop.out", 32'(peek_out), 20);
    check_model("peek");

    // Half full with overflow set is not reachable directly; set overflow, drain to half, then flush.
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) step(1, 40 + k, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0);
    check("half.overflow", 32'(overflow), 1);
    check("half.count",    32'(count),    4);
    step(1, 99, 0, 1, 0);
    check("flush.count",    32'(count),    0);
    check("flush.empty",    32'(empty),    1);
    check("flush.overflow", 32'(overflow), 0);
    step(0, 0, 0, 0, 0);
    check("flush.not_stored", 32'(count), 0);

    // Asynchronous reset between edges.
    step(1, 11, 0, 0, 0);
    step(1, 12, 0, 0, 0);
    step(1, 13, 1, 0, 1);
    #2;
    rst = 0;
    #1;
    model_reset();
    check("arst.count",     32'(count),     0);
    check("arst.empty",     32'(empty),     1);
    check("arst.overflow",  32'(overflow),  0);
    check("arst.underflow", 32'(underflow), 0);
    check("arst.peek_valid", 32'(peek_valid), 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    step(1, 7, 0, 0, 0);
    check("arst.push7", 32'(val_out), 7);
    check_model("arst");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 55, int'($urandom_range(0, 255)), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, int'($urandom_range(0, DEPTH - 1)));
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
